// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser
//   Turns a stream of ASCII characters from the UART receiver into a binary
//   word. Hex digits are shifted into an accumulator. A CR or LF releases the
//   finished word on value. Backspace removes the last digit, and ESC abandons
//   the line. An illegal character or too many digits raises error, and the
//   rest of the line is then discarded.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   rx_data      received ASCII byte, sampled only while rx_ready=1
//   rx_ready     one-cycle strobe marking a new character
//   value        last completed word, right-aligned and zero-extended
//   value_valid  one-cycle pulse when value has just been updated
//   digit_count  number of digits currently accumulated
//   error        one-cycle pulse on an illegal character or an overflow
//   busy         high while a line is in progress (ACCUM or DISCARD)
module ascii_hex_parser #(
  parameter  int N_DIGITS = 8,
  localparam int W        = 4 * N_DIGITS,
  localparam int CW       = $clog2(N_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_ready,
  output logic [W-1:0]  value,
  output logic          value_valid,
  output logic [CW-1:0] digit_count,
  output logic          error,
  output logic          busy
);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DISCARD} state_e;
  typedef enum logic [2:0] {C_HEX, C_TERM, C_BS, C_ESC, C_OTHER} char_class_e;

  state_e      state_q, state_d;
  logic [W-1:0]  acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  value_q, value_d;
  logic          valid_q, valid_d;
  logic          error_q, error_d;
  logic          busy_q, busy_d;

  char_class_e cls;
  logic [3:0]  nib;

  // Classify the incoming byte and convert hex digits to their nibble value.
  // NOTE: every signal driven in always_comb gets a default first, so that no
  // path through the block leaves it unassigned and a latch is inferred.
  always_comb begin
    cls = C_OTHER;
    nib = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      cls = C_HEX;
      nib = rx_data[3:0];
    end else if ((rx_data >= 8'h41 && rx_data <= 8'h46) ||
                 (rx_data >= 8'h61 && rx_data <= 8'h66)) begin
      cls = C_HEX;
      // 'A'/'a' have 1 in the low nibble, so adding 9 gives 0xA.
      nib = rx_data[3:0] + 4'd9;
    end else if (rx_data == 8'h0D || rx_data == 8'h0A) begin
      cls = C_TERM;
    end else if (rx_data == 8'h08 || rx_data == 8'h7F) begin
      cls = C_BS;
    end else if (rx_data == 8'h1B) begin
      cls = C_ESC;
    end
  end

  // Next-state logic. The pulses default low, so they last one cycle.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    value_d = value_q;
    valid_d = 1'b0;
    error_d = 1'b0;

    if (rx_ready) begin
      unique case (state_q)
        S_IDLE: begin
          if (cls == C_HEX) begin
            acc_d   = W'(nib);
            cnt_d   = CW'(1);
            state_d = S_ACCUM;
          end else if (cls == C_OTHER) begin
            error_d = 1'b1;
            state_d = S_DISCARD;
          end
        end

        S_ACCUM: begin
          unique case (cls)
            C_HEX: begin
              if (cnt_q < CW'(N_DIGITS)) begin
                acc_d = {acc_q[W-5:0], nib};
                cnt_d = cnt_q + CW'(1);
              end else begin
                error_d = 1'b1;
                acc_d   = '0;
                cnt_d   = '0;
                state_d = S_DISCARD;
              end
            end
            C_TERM: begin
              // cnt_q is at least 1 in ACCUM, so an empty line never gets here.
              value_d = acc_q;
              valid_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end
            C_BS: begin
              acc_d = acc_q >> 4;
              cnt_d = cnt_q - CW'(1);
              if (cnt_q == CW'(1)) state_d = S_IDLE;
            end
            C_ESC: begin
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_IDLE;
            end
            default: begin
              error_d = 1'b1;
              acc_d   = '0;
              cnt_d   = '0;
              state_d = S_DISCARD;
            end
          endcase
        end

        S_DISCARD: begin
          if (cls == C_TERM || cls == C_ESC) state_d = S_IDLE;
        end

        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy_d = (state_d != S_IDLE);

  // NOTE: every register, including the accumulator and value, is cleared by
  // the asynchronous reset, so a partial word is dropped the moment rst_n
  // falls.
  // NOTE: sequential state uses non-blocking assignments, so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      value_q <= '0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
      valid_q <= valid_d;
      error_q <= error_d;
      busy_q  <= busy_d;
    end
  end

  assign value       = value_q;
  assign value_valid = valid_q;
  assign digit_count = cnt_q;
  assign error       = error_q;
  assign busy        = busy_q;

endmodule
